// File: rtl/memory_elements_pkg.sv
// Shared types and helpers for the memory-element family (register banks, PISO).
package memory_elements_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shifter with valid/ready intake and a one-word hold
// buffer so consecutive words stream out without a gap.
module piso_shift_reg
  import memory_elements_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  input  logic             SHIFT_EN,
  output logic             Q,
  output logic             Q_VALID,
  output logic             Q_LAST,
  output logic             BUSY
);

  localparam int unsigned     CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;

  logic             w_accept;
  logic             w_at_last;
  logic             w_word_end;
  logic [WIDTH-1:0] w_shifted;
  logic             w_out_bit;

  assign w_at_last  = (r_cnt == LAST_CNT);
  assign w_accept   = D_VALID & D_READY;
  assign w_word_end = (r_state == SHIFT) & SHIFT_EN & w_at_last;

  // Move the word one place toward the output end, zero filling behind it.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
      assign w_out_bit = r_sreg[WIDTH-1];
    end else begin : g_lsb
      assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
      assign w_out_bit = r_sreg[0];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sreg  <= D;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (SHIFT_EN) begin
            if (!w_at_last) begin
              r_sreg <= w_shifted;
              r_cnt  <= r_cnt + CNT_W'(1);
            end else if (r_hold_full) begin
              r_sreg      <= r_hold;
              r_hold_full <= 1'b0;
              r_cnt       <= '0;
            end else if (w_accept) begin
              r_sreg <= D;
              r_cnt  <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
          // A word arriving mid-shift parks in the hold buffer.
          if (w_accept && !w_word_end) begin
            r_hold      <= D;
            r_hold_full <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Q_VALID = (r_state == SHIFT);
  assign Q       = Q_VALID & w_out_bit;
  assign Q_LAST  = Q_VALID & w_at_last;
  assign BUSY    = (r_state == SHIFT) | r_hold_full;
  assign D_READY = (r_state == IDLE) | ~r_hold_full;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: directed scenarios plus random traffic scored
// against a word-queue model of the serial stream.
module tb_piso_shift_reg;

  logic       CLK;
  logic       RST_N;
  logic [3:0] D;
  logic       D_VALID;
  logic       SHIFT_EN;

  logic q_m, qv_m, ql_m, busy_m, rdy_m;
  logic q_l, qv_l, ql_l, busy_l, rdy_l;

  int n_cmp;
  int n_bad;

  // Model: words still owed to the consumer, and bits already taken from the first.
  logic [3:0] m_words[$];
  int         m_pos;

  piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .RST_N(RST_N), .D(D), .D_VALID(D_VALID), .D_READY(rdy_m),
    .SHIFT_EN(SHIFT_EN), .Q(q_m), .Q_VALID(qv_m), .Q_LAST(ql_m), .BUSY(busy_m)
  );

  piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .RST_N(RST_N), .D(D), .D_VALID(D_VALID), .D_READY(rdy_l),
    .SHIFT_EN(SHIFT_EN), .Q(q_l), .Q_VALID(qv_l), .Q_LAST(ql_l), .BUSY(busy_l)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Called at a negedge: apply inputs, cross one rising edge, update the model.
  task automatic step(input logic [3:0] d, input logic v, input logic se);
    logic acc;
    logic cons;
    D        = d;
    D_VALID  = v;
    SHIFT_EN = se;
    acc  = v && (m_words.size() < 2);
    cons = se && (m_words.size() > 0);
    @(posedge CLK);
    if (cons) begin
      m_pos++;
      if (m_pos == 4) begin
        void'(m_words.pop_front());
        m_pos = 0;
      end
    end
    if (acc) m_words.push_back(d);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    D_VALID = 1'b0;
    SHIFT_EN = 1'b0;
    m_words.delete();
    m_pos = 0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({q_m, qv_m, ql_m, busy_m, rdy_m} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_msb: got Q/QV/QL/BUSY/RDY=%b want 00001", {q_m, qv_m, ql_m, busy_m, rdy_m});
    end
    n_cmp++;
    if ({q_l, qv_l, ql_l, busy_l, rdy_l} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_lsb: got Q/QV/QL/BUSY/RDY=%b want 00001", {q_l, qv_l, ql_l, busy_l, rdy_l});
    end
  endtask

  task automatic test_single_word();
    logic [3:0] exp_q;
    exp_q = 4'b1011;
    do_reset();
    step(4'b1011, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({qv_m, q_m, ql_m} !== {1'b1, exp_q[3-i], (i == 3)}) begin
        n_bad++;
        $display("FAIL single_bit%0d: got V/Q/L=%b%b%b want 1%b%b", i, qv_m, q_m, ql_m, exp_q[3-i], (i == 3));
      end
      step(4'b0000, 1'b0, 1'b1);
    end
    n_cmp++;
    if ({qv_m, q_m, busy_m} !== 3'b000) begin
      n_bad++;
      $display("FAIL single_done: got V/Q/BUSY=%b want 000", {qv_m, q_m, busy_m});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q;
    exp_q = 8'b1011_0110;
    do_reset();
    step(4'b1011, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({qv_m, q_m, ql_m} !== {1'b1, exp_q[7-i], (i == 3 || i == 7)}) begin
        n_bad++;
        $display("FAIL b2b_bit%0d: got V/Q/L=%b%b%b want 1%b%b", i, qv_m, q_m, ql_m, exp_q[7-i], (i == 3 || i == 7));
      end
      n_cmp++;
      if (rdy_m !== !(i >= 1 && i <= 3)) begin
        n_bad++;
        $display("FAIL b2b_ready%0d: got %b want %b", i, rdy_m, !(i >= 1 && i <= 3));
      end
      step(4'b0110, (i == 0), 1'b1);
    end
    n_cmp++;
    if ({qv_m, busy_m} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_done: got V/BUSY=%b want 00", {qv_m, busy_m});
    end
  endtask

  task automatic test_stall();
    logic [6:0] exp_q;
    logic [6:0] exp_l;
    logic [6:0] se;
    exp_q = 7'b1111100;
    exp_l = 7'b0000001;
    se    = 7'b1000111;
    do_reset();
    step(4'b1100, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if ({qv_m, q_m, ql_m} !== {1'b1, exp_q[6-i], exp_l[6-i]}) begin
        n_bad++;
        $display("FAIL stall_cyc%0d: got V/Q/L=%b%b%b want 1%b%b", i, qv_m, q_m, ql_m, exp_q[6-i], exp_l[6-i]);
      end
      step(4'b0000, 1'b0, se[6-i]);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] exp_q;
    exp_q = 4'b0001;
    do_reset();
    step(4'b1011, 1'b1, 1'b1);
    step(4'b0110, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({q_m, qv_m, ql_m, busy_m, rdy_m} !== 5'b00001) begin
      n_bad++;
      $display("FAIL midreset_async: got Q/QV/QL/BUSY/RDY=%b want 00001", {q_m, qv_m, ql_m, busy_m, rdy_m});
    end
    m_words.delete();
    m_pos = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({qv_m, busy_m} !== 2'b00) begin
      n_bad++;
      $display("FAIL midreset_no_replay: got V/BUSY=%b want 00", {qv_m, busy_m});
    end
    step(4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({qv_m, q_m, ql_m} !== {1'b1, exp_q[3-i], (i == 3)}) begin
        n_bad++;
        $display("FAIL midreset_bit%0d: got V/Q/L=%b%b%b want 1%b%b", i, qv_m, q_m, ql_m, exp_q[3-i], (i == 3));
      end
      step(4'b0000, 1'b0, 1'b1);
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp_q;
    exp_q = 4'b1000;
    do_reset();
    step(4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({qv_l, q_l, ql_l, busy_l} !== {1'b1, exp_q[3-i], (i == 3), 1'b1}) begin
        n_bad++;
        $display("FAIL lsb_bit%0d: got V/Q/L/BUSY=%b%b%b%b want 1%b%b1", i, qv_l, q_l, ql_l, busy_l, exp_q[3-i], (i == 3));
      end
      step(4'b0000, 1'b0, 1'b1);
    end
  endtask

  task automatic test_random();
    logic [3:0] w;
    logic       e_v, e_q, e_l, e_b, e_r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      e_v = (m_words.size() > 0);
      e_q = 1'b0;
      e_l = 1'b0;
      if (e_v) begin
        w   = m_words[0];
        e_q = w[3-m_pos];
        e_l = (m_pos == 3);
      end
      e_b = e_v;
      e_r = (m_words.size() < 2);
      n_cmp++;
      if ({qv_m, q_m, ql_m, busy_m, rdy_m} !== {e_v, e_q, e_l, e_b, e_r}) begin
        n_bad++;
        $display("FAIL random_cyc%0d: got V/Q/L/BUSY/RDY=%b want %b", c,
                 {qv_m, q_m, ql_m, busy_m, rdy_m}, {e_v, e_q, e_l, e_b, e_r});
      end
      step(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    m_pos    = 0;
    RST_N    = 1'b0;
    D        = '0;
    D_VALID  = 1'b0;
    SHIFT_EN = 1'b0;
    test_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    test_single_word();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_lsb_first();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
